// File: rtl/adder_tree_pipe_if.sv
// Handshake bundle for adder_tree_pipe: input beat (valid/ready/data/mask) and result stream.
// out_ovf exists only when ADDER_TREE_OVF_EN is defined.
interface adder_tree_pipe_if #(
   parameter int NUM_IN    = 8,
   parameter int IN_WIDTH  = 10,
   parameter int OUT_WIDTH = 13
);
   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_IN*IN_WIDTH-1:0]   in_data;
   logic [NUM_IN-1:0]            in_mask;
   logic                         out_valid;
   logic                         out_ready;
   logic [OUT_WIDTH-1:0]         out_data;
`ifdef ADDER_TREE_OVF_EN
   logic                         out_ovf;

   modport master (output in_valid, in_data, in_mask, out_ready,
                   input  in_ready, out_valid, out_data, out_ovf);
   modport slave  (input  in_valid, in_data, in_mask, out_ready,
                   output in_ready, out_valid, out_data, out_ovf);
`else
   modport master (output in_valid, in_data, in_mask, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, in_mask, out_ready,
                   output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/adder_tree_pipe.sv
// Pipelined masked N-lane adder tree, one register stage per level, global-stall valid/ready.
// Define ADDER_TREE_OVF_EN to saturate on overflow and drive out_ovf; otherwise the sum wraps.
module adder_tree_pipe #(
   parameter int NUM_IN    = 8,
   parameter int IN_WIDTH  = 10,
   parameter int OUT_WIDTH = 13,
   parameter bit SIGNED    = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   adder_tree_pipe_if.slave  bus
);
   localparam int LEVELS = $clog2(NUM_IN);
   localparam int FULL_W = IN_WIDTH + LEVELS + 1;

   logic                 adv;
   logic [LEVELS:1]      valid_q, valid_d, load;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [FULL_W-1:0]    full_sum;

   // Stage L loads only when the pipe advances and its upstream holds a real beat.
   always_comb begin
      adv        = ~valid_q[LEVELS] | bus.out_ready;
      load[1]    = adv & bus.in_valid;
      valid_d[1] = adv ? bus.in_valid : valid_q[1];
      for (int l = 2; l <= LEVELS; l++) begin
         load[l]    = adv & valid_q[l-1];
         valid_d[l] = adv ? valid_q[l-1] : valid_q[l];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Level 0 is the masked, extended input; the root level is left combinational and
   // feeds the output register, which is the last of the LEVELS stages.
   for (genvar gi = 0; gi <= LEVELS; gi++) begin : g_lvl
      localparam int NODES = NUM_IN >> gi;
      localparam int LW    = IN_WIDTH + gi + 1;
      logic [LW-1:0] node [NODES];

      if (gi == 0) begin : g_leaf
         logic [IN_WIDTH-1:0] lane;
         always_comb begin
            lane = '0;
            for (int k = 0; k < NUM_IN; k++) begin
               lane    = bus.in_data[k*IN_WIDTH +: IN_WIDTH];
               node[k] = bus.in_mask[k] ? {SIGNED && lane[IN_WIDTH-1], lane} : '0;
            end
         end
      end else begin : g_sum
         logic [LW-1:0] sum [NODES];
         always_comb begin
            for (int k = 0; k < NODES; k++) begin
               sum[k] = {SIGNED && g_lvl[gi-1].node[2*k][LW-2],   g_lvl[gi-1].node[2*k]}
                      + {SIGNED && g_lvl[gi-1].node[2*k+1][LW-2], g_lvl[gi-1].node[2*k+1]};
            end
         end

         if (gi < LEVELS) begin : g_reg
            logic [LW-1:0] node_q [NODES];
            logic [LW-1:0] node_d [NODES];
            always_comb begin
               for (int k = 0; k < NODES; k++) node_d[k] = load[gi] ? sum[k] : node_q[k];
            end
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  for (int k = 0; k < NODES; k++) node_q[k] <= '0;
               end else begin
                  for (int k = 0; k < NODES; k++) node_q[k] <= node_d[k];
               end
            end
            assign node = node_q;
         end else begin : g_root
            assign node = sum;
         end
      end
   end

   assign full_sum = g_lvl[LEVELS].node[0];

`ifdef ADDER_TREE_OVF_EN
   logic                 out_ovf_q, out_ovf_d;
   logic                 ovf;
   logic [OUT_WIDTH-1:0] sat_val;

   if (SIGNED) begin : g_sat_s
      assign ovf     = full_sum[FULL_W-1:OUT_WIDTH-1] != {(FULL_W-OUT_WIDTH+1){full_sum[FULL_W-1]}};
      assign sat_val = full_sum[FULL_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                          : {1'b0, {(OUT_WIDTH-1){1'b1}}};
   end else begin : g_sat_u
      assign ovf     = |full_sum[FULL_W-1:OUT_WIDTH];
      assign sat_val = '1;
   end

   always_comb begin
      out_data_d = out_data_q;
      out_ovf_d  = out_ovf_q;
      if (load[LEVELS]) begin
         out_data_d = ovf ? sat_val : full_sum[OUT_WIDTH-1:0];
         out_ovf_d  = ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_ovf_q <= 1'b0;
      else        out_ovf_q <= out_ovf_d;
   end

   assign bus.out_ovf = out_ovf_q;
`else
   logic unused_sum_hi;
   assign unused_sum_hi = ^full_sum[FULL_W-1:OUT_WIDTH];

   always_comb begin
      out_data_d = load[LEVELS] ? full_sum[OUT_WIDTH-1:0] : out_data_q;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_data_q <= '0;
      else        out_data_q <= out_data_d;
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = valid_q[LEVELS];
   assign bus.out_data  = out_data_q;
endmodule
